// File: rtl/pt_feeder_pkg.sv
// Shared point/nibble definitions for the point feeder and the convex-hull engine.
package pt_feeder_pkg;
  localparam int COORD_W     = 10;
  localparam int NIB_W       = 5;
  localparam int NIBS_PER_PT = 4;
  localparam int PT_W        = 2 * COORD_W;

  // Order in which a point's nibbles go out on PT_XY
  typedef enum logic [1:0] {
    NIB_XH = 2'd0,
    NIB_XL = 2'd1,
    NIB_YH = 2'd2,
    NIB_YL = 2'd3
  } nib_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } pt_t;

  function automatic logic [NIB_W-1:0] nib_sel(input pt_t p, input nib_e idx);
    logic [NIB_W-1:0] n;
    case (idx)
      NIB_XH:  n = p.x[COORD_W-1:NIB_W];
      NIB_XL:  n = p.x[NIB_W-1:0];
      NIB_YH:  n = p.y[COORD_W-1:NIB_W];
      default: n = p.y[NIB_W-1:0];
    endcase
    return n;
  endfunction
endpackage

// File: rtl/pt_fifo.sv
// Synchronous point FIFO; head entry is presented combinationally on dout.
module pt_fifo
  import pt_feeder_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic CLK,
  input  logic RST,
  input  logic push,
  input  pt_t  din,
  input  logic pop,
  output pt_t  dout,
  output logic full,
  output logic empty
);
  pt_t           mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  assign dout  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // Storage is not reset; occupancy alone decides what is valid
  always_ff @(posedge CLK)
    if (push) mem[wr_ptr] <= din;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/pt_feeder.sv
// Buffers producer points and serialises each as four 5-bit nibbles on READ_PT.
module pt_feeder
  import pt_feeder_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [COORD_W-1:0] IN_X,
  input  logic [COORD_W-1:0] IN_Y,
  input  logic               IN_V,
  output logic               IN_RDY,
  input  logic               READ_PT,
  output logic [NIB_W-1:0]   PT_XY,
  output logic               UNDERRUN,
  output logic [7:0]         PT_SENT
);
  nib_e             nib_q, nib_d;
  logic             push, pop, full, empty;
  pt_t              head;
  logic [NIB_W-1:0] xy_d;
  logic             und_d;

  // A full FIFO still takes a point on the cycle the head's last nibble leaves
  assign IN_RDY = !full || pop;
  assign push   = IN_V && IN_RDY;

  pt_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .din   ('{x: IN_X, y: IN_Y}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) nib_q <= NIB_XH;
    else     nib_q <= nib_d;
  end

  always_comb begin
    nib_d = nib_q;
    pop   = 1'b0;
    xy_d  = PT_XY;
    und_d = UNDERRUN;
    if (READ_PT) begin
      if (empty) begin
        xy_d  = '0;
        und_d = 1'b1;
      end else begin
        xy_d = nib_sel(head, nib_q);
        if (nib_q == NIB_YL) begin
          pop   = 1'b1;
          nib_d = NIB_XH;
        end else begin
          nib_d = nib_e'(nib_q + 2'd1);
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PT_XY    <= '0;
      UNDERRUN <= 1'b0;
      PT_SENT  <= '0;
    end else begin
      PT_XY    <= xy_d;
      UNDERRUN <= und_d;
      if (pop) PT_SENT <= PT_SENT + 8'd1;
    end
  end
endmodule

// File: tb/tb_pt_feeder.sv
// Directed bench for pt_feeder: queue-based point model checked every cycle plus literal pins.
module tb_pt_feeder;
  localparam int DEPTH = 8;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [9:0] IN_X = '0, IN_Y = '0;
  logic       IN_V = 1'b0, READ_PT = 1'b0;
  logic       IN_RDY, UNDERRUN;
  logic [4:0] PT_XY;
  logic [7:0] PT_SENT;

  pt_feeder #(.DEPTH(DEPTH), .AW(3)) dut (
    .CLK(CLK), .RST(RST), .IN_X(IN_X), .IN_Y(IN_Y), .IN_V(IN_V), .IN_RDY(IN_RDY),
    .READ_PT(READ_PT), .PT_XY(PT_XY), .UNDERRUN(UNDERRUN), .PT_SENT(PT_SENT)
  );

  always #5 CLK = ~CLK;

  int n_pass = 0, n_tot = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: a queue of 20-bit {x,y} points, nibble position within the head, outputs
  logic [19:0] m_q[$];
  int          m_nib = 0, m_xy = 0, m_sent = 0;
  bit          m_und = 0;

  function automatic int m_pop_now();
    return (READ_PT && m_q.size() > 0 && m_nib == 3) ? 1 : 0;
  endfunction

  always @(negedge CLK) begin
    chk("in_rdy",   IN_RDY,   (m_q.size() < DEPTH || m_pop_now() != 0) ? 1 : 0);
    chk("pt_xy",    PT_XY,    m_xy);
    chk("underrun", UNDERRUN, m_und);
    chk("pt_sent",  PT_SENT,  m_sent % 256);
  end

  // One clock: drive inputs, advance the model at the edge, return just after negedge
  task automatic step(input bit v, input logic [9:0] x, input logic [9:0] y, input bit rd,
                      output bit rdy_pre);
    bit popped, acc;
    IN_V = v; IN_X = x; IN_Y = y; READ_PT = rd;
    #1 rdy_pre = IN_RDY;
    @(posedge CLK);
    popped = m_pop_now() != 0;
    acc    = v && (m_q.size() < DEPTH || popped);
    if (rd) begin
      if (m_q.size() == 0) begin
        m_xy = 0; m_und = 1;
      end else begin
        m_xy = int'((m_q[0] >> (15 - 5 * m_nib)) & 20'h1f);
        if (m_nib == 3) begin
          void'(m_q.pop_front()); m_nib = 0; m_sent++;
        end else m_nib++;
      end
    end
    if (acc) m_q.push_back({x, y});
    @(negedge CLK); #1;
  endtask

  task automatic do_reset();
    IN_V = 0; READ_PT = 0; RST = 1;
    m_q.delete(); m_nib = 0; m_xy = 0; m_und = 0; m_sent = 0;
    #1;
    chk("rst_in_rdy", IN_RDY, 1);
    chk("rst_pt_xy",  PT_XY,  0);
    chk("rst_sent",   PT_SENT, 0);
    chk("rst_under",  UNDERRUN, 0);
    @(negedge CLK); #1 RST = 0;
  endtask

  // Push one point then request its four nibbles, returning them packed
  task automatic send_pt(input logic [9:0] x, input logic [9:0] y, output logic [19:0] got);
    bit r;
    step(1, x, y, 0, r);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, r);
      got = {got[14:0], PT_XY};
    end
  endtask

  logic [19:0] got;
  logic [19:0] sent_pts[256];
  bit          r;

  initial begin
    @(negedge CLK); #1;
    do_reset();

    // Single point, literal nibbles
    step(1, 10'h2A5, 10'h113, 0, r);
    step(0, 0, 0, 1, r); chk("t1_n0", PT_XY, 5'h15);
    step(0, 0, 0, 1, r); chk("t1_n1", PT_XY, 5'h05);
    step(0, 0, 0, 1, r); chk("t1_n2", PT_XY, 5'h08);
    step(0, 0, 0, 1, r); chk("t1_n3", PT_XY, 5'h13);
    chk("t1_sent", PT_SENT, 1);
    chk("t1_rdy",  IN_RDY, 1);

    // Fill, then push-with-pop on a full FIFO
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1, 10'(i + 1), 10'(i + 17), 0, r);
    chk("full_rdy", IN_RDY, 0);
    for (int i = 0; i < 3; i++) step(1, 10'h3AB, 10'h0CD, 1, r);
    step(1, 10'h3AB, 10'h0CD, 1, r);
    chk("full_pushpop_rdy", r, 1);
    chk("full_pt_xy", PT_XY, 5'h11);
    step(0, 0, 0, 0, r);
    chk("still_full", IN_RDY, 0);
    for (int i = 0; i < DEPTH * 4; i++) step(0, 0, 0, 1, r);
    chk("ninth_last_nib", PT_XY, 5'h0D);
    chk("fill_sent", PT_SENT, 9);

    // Underrun from empty, then a clean point
    do_reset();
    step(0, 0, 0, 1, r);
    chk("ur_xy", PT_XY, 0);
    chk("ur_flag", UNDERRUN, 1);
    step(1, 10'h2A5, 10'h113, 1, r);
    chk("ur_same_cycle_xy", PT_XY, 0);
    step(0, 0, 0, 1, r); chk("ur_n0", PT_XY, 5'h15);
    step(0, 0, 0, 1, r); chk("ur_n1", PT_XY, 5'h05);
    step(0, 0, 0, 1, r); chk("ur_n2", PT_XY, 5'h08);
    step(0, 0, 0, 1, r); chk("ur_n3", PT_XY, 5'h13);
    chk("ur_sticky", UNDERRUN, 1);

    // Gapped requests with 3 idle cycles between nibbles
    do_reset();
    step(1, 10'h155, 10'h2AA, 0, r);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, r);
      for (int j = 0; j < 3; j++) step(0, 0, 0, 0, r);
      chk("gap_hold", PT_XY, (i == 0 || i == 3) ? 5'h0A : 5'h15);
    end
    chk("gap_sent", PT_SENT, 1);

    // Reset mid-point with three points queued
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 10'(100 + i), 10'(200 + i), 0, r);
    step(0, 0, 0, 1, r);
    step(0, 0, 0, 1, r);
    do_reset();
    send_pt(10'h2A5, 10'h113, got);
    chk("post_rst_pt", got, 20'h2A513 >> 0 == 20'h2A513 ? {5'h15, 5'h05, 5'h08, 5'h13} : 0);
    chk("post_rst_sent", PT_SENT, 1);

    // 256 points: wrap and scoreboard
    do_reset();
    for (int i = 0; i < 256; i++) begin
      sent_pts[i] = 20'($urandom);
      send_pt(sent_pts[i][19:10], sent_pts[i][9:0], got);
      chk("sb_point", got, sent_pts[i]);
    end
    chk("wrap_sent", PT_SENT, 0);
    chk("wrap_under", UNDERRUN, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
